// File: rtl/wm_panel_pkg.sv
// Shared types, encodings and defaults for the washing-machine front panel.
// Both the panel FSM and the phase display decode rely on these definitions.
package wm_panel_pkg;

    typedef logic [2:0] pnl_state_t;

    localparam pnl_state_t PNL_OFF     = 3'd0;
    localparam pnl_state_t PNL_SELECT  = 3'd1;
    localparam pnl_state_t PNL_RUNNING = 3'd2;
    localparam pnl_state_t PNL_CANCEL  = 3'd3;
    localparam pnl_state_t PNL_DONE    = 3'd4;

    typedef enum logic [2:0] {
        PH_NONE  = 3'd0,
        PH_SOAK  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_t;

    localparam int DEF_DEB_CYCLES    = 5;
    localparam int DEF_TICKS_PER_SEC = 250;
    localparam int DEF_CANCEL_CYCLES = 4;
    localparam int DEF_BUZZ_CYCLES   = 750;

    localparam logic [11:0] PHASE_SEC_MAX = 12'hFFF;

    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? 2'd1 : mode + 2'd1;
    endfunction

    function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
        case (mode)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Later wash stages take precedence when the controller flags overlap.
    function automatic phase_t decode_phase(input logic spin, input logic rinse,
                                            input logic wash, input logic soak);
        if (spin)       return PH_SPIN;
        else if (rinse) return PH_RINSE;
        else if (wash)  return PH_WASH;
        else if (soak)  return PH_SOAK;
        else            return PH_NONE;
    endfunction

endpackage

// File: rtl/wm_panel_ctrl_debounce.sv
// Single-input debouncer: the filtered level follows the raw input only after
// the raw value has been stable for DEB_CYCLES consecutive clocks.
module wm_debounce
    import wm_panel_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;

    // Any sample that agrees with the current level restarts the stability run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (i_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_level <= i_raw;
                r_rise  <= i_raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/wm_panel_ctrl.sv
// Front-panel sequencer: debounces the panel inputs, issues controller commands
// and turns controller status into mode/phase/elapsed-time display data.
module wm_panel_ctrl
    import wm_panel_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int CANCEL_CYCLES = DEF_CANCEL_CYCLES,
    parameter int BUZZ_CYCLES   = DEF_BUZZ_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn_start,
    input  logic        i_btn_cancel,
    input  logic        i_btn_mode,
    input  logic        i_coin_sensor,
    input  logic        i_lid_sw,
    input  logic        i_idle,
    input  logic        i_ready,
    input  logic        i_soak,
    input  logic        i_wash,
    input  logic        i_rinse,
    input  logic        i_spin,
    input  logic        i_coinreturn,
    input  logic        i_done,
    output logic        o_start,
    output logic        o_coin,
    output logic        o_cancel,
    output logic        o_mode_1,
    output logic        o_mode_2,
    output logic        o_mode_3,
    output logic        o_lid,
    output logic [1:0]  o_mode_sel,
    output logic [2:0]  o_phase,
    output logic [11:0] o_phase_sec,
    output logic        o_buzzer,
    output logic        o_refund_led
);

    localparam int CNT_W = 16;
    localparam int PRE_W = $clog2(TICKS_PER_SEC + 1);

    logic w_start_rise, w_cancel_rise, w_mode_rise, w_coin_rise;
    logic w_start_lvl_unused, w_cancel_lvl_unused, w_mode_lvl_unused, w_coin_lvl_unused;
    logic w_lid, w_lid_rise_unused;
    logic w_status_unused;
    logic w_done_rise;
    logic [1:0] w_mode_next;
    phase_t w_phase_next;

    pnl_state_t       r_state;
    logic             r_start, r_coin, r_cancel, r_buzzer, r_refund, r_done_d;
    logic [2:0]       r_mode_oh;
    logic [1:0]       r_mode_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_phase;
    logic [PRE_W-1:0] r_pre;
    logic [11:0]      r_sec;

    wm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_start),
        .o_level(w_start_lvl_unused), .o_rise(w_start_rise));
    wm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancel (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_cancel),
        .o_level(w_cancel_lvl_unused), .o_rise(w_cancel_rise));
    wm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_mode),
        .o_level(w_mode_lvl_unused), .o_rise(w_mode_rise));
    wm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_coin (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_coin_sensor),
        .o_level(w_coin_lvl_unused), .o_rise(w_coin_rise));
    wm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lid (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_lid_sw),
        .o_level(w_lid), .o_rise(w_lid_rise_unused));

    assign w_status_unused = i_idle ^ i_ready;
    assign w_done_rise     = i_done & ~r_done_d;
    assign w_mode_next     = w_mode_rise ? next_mode(r_mode_sel) : r_mode_sel;
    assign w_phase_next    = decode_phase(i_spin, i_rinse, i_wash, i_soak);

    // A coin is acknowledged with o_coin first; the mode level follows one
    // cycle later, which is why RUNNING latches the mode while r_coin is set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= PNL_OFF;
            r_start    <= 1'b0;
            r_coin     <= 1'b0;
            r_cancel   <= 1'b0;
            r_buzzer   <= 1'b0;
            r_refund   <= 1'b0;
            r_done_d   <= 1'b0;
            r_mode_oh  <= 3'b000;
            r_mode_sel <= 2'd1;
            r_cnt      <= '0;
        end else begin
            r_start  <= 1'b0;
            r_coin   <= 1'b0;
            r_done_d <= i_done;
            case (r_state)
                PNL_OFF: begin
                    if (w_start_rise) begin
                        r_start <= 1'b1;
                        r_state <= PNL_SELECT;
                    end
                end
                PNL_SELECT: begin
                    if (w_cancel_rise) begin
                        r_cancel <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= PNL_CANCEL;
                    end else begin
                        r_mode_sel <= w_mode_next;
                        if (w_coin_rise) begin
                            r_coin   <= 1'b1;
                            r_refund <= 1'b0;
                            r_state  <= PNL_RUNNING;
                        end
                    end
                end
                PNL_RUNNING: begin
                    if (r_coin)
                        r_mode_oh <= mode_onehot(r_mode_sel);
                    if (w_cancel_rise) begin
                        r_mode_oh <= 3'b000;
                        r_cancel  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= PNL_CANCEL;
                    end else if (w_done_rise) begin
                        r_cnt   <= '0;
                        r_state <= PNL_DONE;
                    end
                end
                PNL_CANCEL: begin
                    if (r_cnt == CNT_W'(CANCEL_CYCLES - 1)) begin
                        r_cancel <= 1'b0;
                        r_state  <= PNL_SELECT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PNL_DONE: begin
                    r_mode_oh <= 3'b000;
                    if (w_start_rise || (r_cnt == CNT_W'(BUZZ_CYCLES))) begin
                        r_buzzer <= 1'b0;
                        r_state  <= PNL_SELECT;
                    end else begin
                        r_buzzer <= 1'b1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= PNL_OFF;
            endcase
            if (i_coinreturn)
                r_refund <= 1'b1;
        end
    end

    // Elapsed time restarts with every phase change and is paused by an open lid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= 3'd0;
            r_pre   <= '0;
            r_sec   <= 12'd0;
        end else begin
            r_phase <= w_phase_next;
            if (w_phase_next != r_phase) begin
                r_pre <= '0;
                r_sec <= 12'd0;
            end else if (!w_lid && (r_phase != PH_NONE)) begin
                if (r_pre == PRE_W'(TICKS_PER_SEC - 1)) begin
                    r_pre <= '0;
                    if (r_sec != PHASE_SEC_MAX)
                        r_sec <= r_sec + 12'd1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    assign o_start      = r_start;
    assign o_coin       = r_coin;
    assign o_cancel     = r_cancel;
    assign o_mode_1     = r_mode_oh[0];
    assign o_mode_2     = r_mode_oh[1];
    assign o_mode_3     = r_mode_oh[2];
    assign o_lid        = w_lid;
    assign o_mode_sel   = r_mode_sel;
    assign o_phase      = r_phase;
    assign o_phase_sec  = r_sec;
    assign o_buzzer     = r_buzzer;
    assign o_refund_led = r_refund;

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Self-checking bench for wm_panel_ctrl: a sample-history behavioural model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_wm_panel_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_start = 0, btn_cancel = 0, btn_mode = 0, coin_sensor = 0, lid_sw = 0;
    logic idle = 0, ready = 0, soak = 0, wash = 0, rinse = 0, spin = 0;
    logic coinreturn = 0, done = 0;

    logic        o_start, o_coin, o_cancel, o_mode_1, o_mode_2, o_mode_3, o_lid;
    logic [1:0]  o_mode_sel;
    logic [2:0]  o_phase;
    logic [11:0] o_phase_sec;
    logic        o_buzzer, o_refund_led;

    int total = 0;
    int bad = 0;
    int cnt_start = 0, cnt_coin = 0, cnt_cancel = 0, cnt_buzz = 0;

    wm_panel_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_btn_start(btn_start), .i_btn_cancel(btn_cancel), .i_btn_mode(btn_mode),
        .i_coin_sensor(coin_sensor), .i_lid_sw(lid_sw),
        .i_idle(idle), .i_ready(ready), .i_soak(soak), .i_wash(wash),
        .i_rinse(rinse), .i_spin(spin), .i_coinreturn(coinreturn), .i_done(done),
        .o_start(o_start), .o_coin(o_coin), .o_cancel(o_cancel),
        .o_mode_1(o_mode_1), .o_mode_2(o_mode_2), .o_mode_3(o_mode_3),
        .o_lid(o_lid), .o_mode_sel(o_mode_sel), .o_phase(o_phase),
        .o_phase_sec(o_phase_sec), .o_buzzer(o_buzzer), .o_refund_led(o_refund_led)
    );

    always #5 clk = ~clk;

    typedef enum {M_OFF, M_SEL, M_RUN, M_CAN, M_DONE} mstate_t;

    // Model state: filtered inputs come from a 5-sample history window
    // (channels: 0 start, 1 cancel, 2 mode, 3 coin, 4 lid).
    int      m_hist[5][5];
    int      m_filt[5];
    int      m_rise[5];
    int      m_raw[5];
    mstate_t m_state;
    int      m_start, m_coin, m_cancel, m_buzz, m_refund;
    int      m_sel, m_mode_on, m_latch_pending;
    int      m_cancel_left, m_buzz_left;
    int      m_done_prev;
    int      m_phase, m_ticks;

    function automatic int spec_phase(input logic sp, input logic ri, input logic wa, input logic so);
        if (sp) return 4;
        if (ri) return 3;
        if (wa) return 2;
        if (so) return 1;
        return 0;
    endfunction

    function automatic int spec_sec(input int ticks);
        return (ticks / 250 > 4095) ? 4095 : ticks / 250;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 5; c++) begin
                for (int i = 0; i < 5; i++) m_hist[c][i] = 0;
                m_filt[c] = 0;
                m_rise[c] = 0;
            end
            m_state = M_OFF;
            m_start = 0; m_coin = 0; m_cancel = 0; m_buzz = 0; m_refund = 0;
            m_sel = 1; m_mode_on = 0; m_latch_pending = 0;
            m_cancel_left = 0; m_buzz_left = 0; m_done_prev = 0;
            m_phase = 0; m_ticks = 0;
        end else begin
            automatic int e_start  = m_rise[0];
            automatic int e_cancel = m_rise[1];
            automatic int e_mode   = m_rise[2];
            automatic int e_coin   = m_rise[3];
            automatic int d_rise   = (done && !m_done_prev) ? 1 : 0;
            automatic int np;
            m_done_prev = done;
            m_start = 0;
            m_coin  = 0;
            case (m_state)
                M_OFF: if (e_start) begin m_start = 1; m_state = M_SEL; end
                M_SEL: begin
                    if (e_cancel) begin
                        m_state = M_CAN; m_cancel_left = 4; m_cancel = 1;
                    end else begin
                        if (e_mode) m_sel = (m_sel % 3) + 1;
                        if (e_coin) begin
                            m_coin = 1; m_latch_pending = 1; m_refund = 0; m_state = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (m_latch_pending) m_mode_on = m_sel;
                    m_latch_pending = 0;
                    if (e_cancel) begin
                        m_mode_on = 0; m_state = M_CAN; m_cancel_left = 4; m_cancel = 1;
                    end else if (d_rise) begin
                        m_state = M_DONE; m_buzz_left = 750;
                    end
                end
                M_CAN: begin
                    m_cancel_left--;
                    if (m_cancel_left == 0) begin m_cancel = 0; m_state = M_SEL; end
                end
                M_DONE: begin
                    m_mode_on = 0;
                    if (e_start || m_buzz_left == 0) begin
                        m_buzz = 0; m_state = M_SEL;
                    end else begin
                        m_buzz = 1; m_buzz_left--;
                    end
                end
                default: m_state = M_OFF;
            endcase
            if (coinreturn) m_refund = 1;

            np = spec_phase(spin, rinse, wash, soak);
            if (np != m_phase) m_ticks = 0;
            else if (m_filt[4] == 0 && m_phase != 0) m_ticks++;
            m_phase = np;

            m_raw[0] = int'(btn_start);  m_raw[1] = int'(btn_cancel);
            m_raw[2] = int'(btn_mode);   m_raw[3] = int'(coin_sensor);
            m_raw[4] = int'(lid_sw);
            for (int c = 0; c < 5; c++) begin
                automatic int same = 1;
                for (int i = 0; i < 4; i++) m_hist[c][i] = m_hist[c][i+1];
                m_hist[c][4] = m_raw[c];
                for (int i = 0; i < 5; i++) if (m_hist[c][i] != m_raw[c]) same = 0;
                m_rise[c] = 0;
                if (same && m_raw[c] != m_filt[c]) begin
                    m_filt[c] = m_raw[c];
                    m_rise[c] = m_raw[c];
                end
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("start",    32'(o_start),      32'(m_start));
        checkOutput("coin",     32'(o_coin),       32'(m_coin));
        checkOutput("cancel",   32'(o_cancel),     32'(m_cancel));
        checkOutput("mode_1",   32'(o_mode_1),     32'(m_mode_on == 1));
        checkOutput("mode_2",   32'(o_mode_2),     32'(m_mode_on == 2));
        checkOutput("mode_3",   32'(o_mode_3),     32'(m_mode_on == 3));
        checkOutput("lid",      32'(o_lid),        32'(m_filt[4]));
        checkOutput("mode_sel", 32'(o_mode_sel),   32'(m_sel));
        checkOutput("phase",    32'(o_phase),      32'(m_phase));
        checkOutput("phase_sec",32'(o_phase_sec),  32'(spec_sec(m_ticks)));
        checkOutput("buzzer",   32'(o_buzzer),     32'(m_buzz));
        checkOutput("refund",   32'(o_refund_led), 32'(m_refund));
        cnt_start  += int'(o_start);
        cnt_coin   += int'(o_coin);
        cnt_cancel += int'(o_cancel);
        cnt_buzz   += int'(o_buzzer);
    end

    task automatic applyStimulus(input logic s, input logic k, input logic m,
                                 input logic c, input logic l, input int n);
        btn_start = s; btn_cancel = k; btn_mode = m; coin_sensor = c; lid_sw = l;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        automatic int snap_a, snap_b;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        checkOutput("lit_reset_mode_sel", 32'(o_mode_sel), 32'd1);
        checkOutput("lit_reset_start", 32'(o_start), 32'd0);
        checkOutput("lit_reset_mode_1", 32'(o_mode_1), 32'd0);

        snap_a = cnt_start;
        applyStimulus(1, 0, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 10);
        checkOutput("lit_glitch_no_start", 32'(cnt_start - snap_a), 32'd0);

        snap_a = cnt_start;
        applyStimulus(1, 0, 0, 0, 0, 10);
        applyStimulus(0, 0, 0, 0, 0, 10);
        checkOutput("lit_start_pulse_len", 32'(cnt_start - snap_a), 32'd1);
        checkOutput("lit_sel_after_start", 32'(o_mode_sel), 32'd1);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 8);
            applyStimulus(0, 0, 0, 0, 0, 8);
        end
        snap_a = cnt_coin;
        applyStimulus(0, 0, 0, 1, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 8);
        checkOutput("lit_coin_pulse_len", 32'(cnt_coin - snap_a), 32'd1);
        checkOutput("lit_mode_sel_3", 32'(o_mode_sel), 32'd3);
        checkOutput("lit_mode_3_on", 32'(o_mode_3), 32'd1);
        checkOutput("lit_mode_1_off", 32'(o_mode_1), 32'd0);
        checkOutput("lit_mode_2_off", 32'(o_mode_2), 32'd0);

        wash = 1;
        applyStimulus(0, 0, 0, 0, 0, 1001);
        checkOutput("lit_phase_wash", 32'(o_phase), 32'd2);
        checkOutput("lit_sec_4", 32'(o_phase_sec), 32'd4);
        applyStimulus(0, 0, 0, 0, 1, 500);
        checkOutput("lit_lid_open", 32'(o_lid), 32'd1);
        checkOutput("lit_sec_frozen", 32'(o_phase_sec), 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 300);
        checkOutput("lit_sec_resumed", 32'(o_phase_sec), 32'd5);

        snap_a = cnt_cancel;
        applyStimulus(0, 1, 0, 0, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 12);
        checkOutput("lit_cancel_len_run", 32'(cnt_cancel - snap_a), 32'd4);
        checkOutput("lit_cancel_clears_mode", 32'(o_mode_3), 32'd0);

        snap_a = cnt_cancel;
        snap_b = cnt_coin;
        applyStimulus(0, 1, 0, 1, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 12);
        checkOutput("lit_cancel_wins_len", 32'(cnt_cancel - snap_a), 32'd4);
        checkOutput("lit_cancel_wins_nocoin", 32'(cnt_coin - snap_b), 32'd0);

        applyStimulus(0, 0, 0, 1, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 8);
        checkOutput("lit_rerun_mode_3", 32'(o_mode_3), 32'd1);

        snap_a = cnt_buzz;
        done = 1;
        applyStimulus(0, 0, 0, 0, 0, 10);
        done = 0;
        applyStimulus(0, 0, 0, 0, 0, 800);
        checkOutput("lit_buzz_len", 32'(cnt_buzz - snap_a), 32'd750);
        checkOutput("lit_buzz_off", 32'(o_buzzer), 32'd0);
        checkOutput("lit_done_clears_mode", 32'(o_mode_3), 32'd0);

        applyStimulus(0, 0, 1, 1, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 8);
        checkOutput("lit_mode_coin_sel", 32'(o_mode_sel), 32'd1);
        checkOutput("lit_mode_coin_latch", 32'(o_mode_1), 32'd1);

        done = 1;
        applyStimulus(0, 0, 0, 0, 0, 5);
        done = 0;
        applyStimulus(0, 0, 0, 0, 0, 20);
        checkOutput("lit_buzz_on", 32'(o_buzzer), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 10);
        checkOutput("lit_start_cuts_buzz", 32'(o_buzzer), 32'd0);

        coinreturn = 1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        coinreturn = 0;
        applyStimulus(0, 0, 0, 0, 0, 3);
        checkOutput("lit_refund_set", 32'(o_refund_led), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 8);
        applyStimulus(0, 0, 0, 0, 0, 8);
        checkOutput("lit_refund_cleared", 32'(o_refund_led), 32'd0);
        checkOutput("lit_run_mode_1", 32'(o_mode_1), 32'd1);

        #2;
        rst = 1'b1;
        #1;
        checkOutput("lit_async_mode_1", 32'(o_mode_1), 32'd0);
        checkOutput("lit_async_mode_sel", 32'(o_mode_sel), 32'd1);
        checkOutput("lit_async_phase", 32'(o_phase), 32'd0);
        checkOutput("lit_async_sec", 32'(o_phase_sec), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        wash = 0;
        applyStimulus(0, 0, 0, 0, 0, 10);
        checkOutput("lit_off_after_reset_start", 32'(o_start), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
